// File: rtl/quiz_answer_judge_if.sv
// Host/contestant-facing signal bundle of the quiz answer judge.
// master = host side that drives start/key/buzzers/answers; slave = the judge.
interface quiz_answer_judge_if #(
  parameter int NUM_PLAYERS = 4
);
  logic                     start;
  logic [1:0]               answerKey;
  logic [NUM_PLAYERS-1:0]   buzz;
  logic [1:0]               answerSel;
  logic                     answerValid;
  logic                     answered;
  logic                     correct;
  logic [2:0]               winnerId;
  logic [7:0]               timeLeft;
  logic [1:0]               phase;
  logic [4*NUM_PLAYERS-1:0] scores;

  modport master (
    output start, answerKey, buzz, answerSel, answerValid,
    input  answered, correct, winnerId, timeLeft, phase, scores
  );

  modport slave (
    input  start, answerKey, buzz, answerSel, answerValid,
    output answered, correct, winnerId, timeLeft, phase, scores
  );
endinterface

// File: rtl/quiz_answer_judge.sv
// Quiz judge: buzzer arbitration, per-phase second countdown, answer check and saturating scores.
// Define SCORE_PENALTY_EN to subtract a point from the winner on a wrong answer or answer timeout.
module quiz_answer_judge #(
  parameter int NUM_PLAYERS        = 4,
  parameter int CLOCK_FREQ         = 50000000,
  parameter int ANSWER_TIME_S      = 10,
  parameter int RESULT_HOLD_CYCLES = 100000000
) (
  input logic               clock,
  input logic               globalReset,
  quiz_answer_judge_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OPEN   = 2'd1,
    ANSWER = 2'd2,
    RESULT = 2'd3
  } phase_t;

  localparam int PRESC_W = $clog2(CLOCK_FREQ + 1);
  localparam int HOLD_W  = $clog2(RESULT_HOLD_CYCLES + 1);
  localparam logic [PRESC_W-1:0] PRESC_MAX   = PRESC_W'(CLOCK_FREQ - 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX    = HOLD_W'(RESULT_HOLD_CYCLES - 1);
  localparam logic [7:0]         ANSWER_TIME = 8'(ANSWER_TIME_S);

`ifdef SCORE_PENALTY_EN
  localparam bit PENALTY_EN = 1'b1;
`else
  localparam bit PENALTY_EN = 1'b0;
`endif

  phase_t                 state, state_d;
  logic [NUM_PLAYERS-1:0] sync1, sync2, prev;
  logic [NUM_PLAYERS-1:0] buzz_edge;
  logic [PRESC_W-1:0]     presc;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [1:0]             key_q, key_d;
  logic [7:0]             time_q, time_d;
  logic [2:0]             winner_q, winner_d, edge_idx;
  logic                   correct_q, correct_d;
  logic                   answered_q;
  logic                   tick, timeout, edge_any, hold_done;
  logic                   score_up, score_down;
  logic [3:0]             score_q [NUM_PLAYERS];

  assign buzz_edge = sync2 & ~prev;
  assign edge_any  = |buzz_edge;
  assign tick      = (presc == PRESC_MAX);
  assign timeout   = tick && (time_q == 8'd1);
  assign hold_done = (hold_cnt == HOLD_MAX);

  // Scan downward so the lowest-indexed simultaneous edge is the one left standing.
  always_comb begin
    edge_idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (buzz_edge[i]) edge_idx = 3'(i);
    end
  end

  always_comb begin
    state_d    = state;
    time_d     = time_q;
    winner_d   = winner_q;
    key_d      = key_q;
    correct_d  = correct_q;
    score_up   = 1'b0;
    score_down = 1'b0;

    if (tick && (state == OPEN || state == ANSWER) && time_q != 8'd0)
      time_d = time_q - 8'd1;

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_d = OPEN;
          key_d   = bus.answerKey;
          time_d  = ANSWER_TIME;
        end
      end
      OPEN: begin
        if (edge_any) begin
          state_d  = ANSWER;
          winner_d = edge_idx;
          time_d   = ANSWER_TIME;
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      ANSWER: begin
        if (bus.answerValid) begin
          state_d    = RESULT;
          correct_d  = (bus.answerSel == key_q);
          score_up   = (bus.answerSel == key_q);
          score_down = (bus.answerSel != key_q);
        end else if (timeout) begin
          state_d    = RESULT;
          correct_d  = 1'b0;
          score_down = 1'b1;
        end
      end
      RESULT: begin
        if (hold_done) begin
          state_d   = IDLE;
          correct_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge globalReset) begin
    if (globalReset) begin
      state      <= IDLE;
      sync1      <= '0;
      sync2      <= '0;
      prev       <= '0;
      presc      <= '0;
      hold_cnt   <= '0;
      key_q      <= '0;
      time_q     <= '0;
      winner_q   <= '0;
      correct_q  <= 1'b0;
      answered_q <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) score_q[i] <= '0;
    end else begin
      sync1      <= bus.buzz;
      sync2      <= sync1;
      prev       <= sync2;
      state      <= state_d;
      key_q      <= key_d;
      time_q     <= time_d;
      winner_q   <= winner_d;
      correct_q  <= correct_d;
      answered_q <= (state_d == RESULT);

      // Every phase entry restarts the second prescaler and the result hold timer.
      if (state_d != state || tick) presc <= '0;
      else                          presc <= presc + 1'b1;

      if (state_d != state)     hold_cnt <= '0;
      else if (state == RESULT) hold_cnt <= hold_cnt + 1'b1;

      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (winner_q == 3'(i)) begin
          if (score_up && score_q[i] != 4'd15)
            score_q[i] <= score_q[i] + 4'd1;
          else if (PENALTY_EN && score_down && score_q[i] != 4'd0)
            score_q[i] <= score_q[i] - 4'd1;
        end
      end
    end
  end

  assign bus.phase    = state;
  assign bus.answered = answered_q;
  assign bus.correct  = correct_q;
  assign bus.winnerId = winner_q;
  assign bus.timeLeft = time_q;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_scores
    assign bus.scores[4*g +: 4] = score_q[g];
  end

endmodule

// File: tb/tb_quiz_answer_judge.sv
// Directed-plus-random bench for quiz_answer_judge with a round-level score/verdict model.
module tb_quiz_answer_judge;
  localparam int NP   = 4;
  localparam int CF   = 10;
  localparam int AT   = 3;
  localparam int HOLD = 5;

  logic clock = 1'b0;
  logic globalReset = 1'b1;

  quiz_answer_judge_if #(.NUM_PLAYERS(NP)) bus ();

  quiz_answer_judge #(
    .NUM_PLAYERS(NP),
    .CLOCK_FREQ(CF),
    .ANSWER_TIME_S(AT),
    .RESULT_HOLD_CYCLES(HOLD)
  ) dut (
    .clock(clock),
    .globalReset(globalReset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_pass  = 0;
  int model_score [NP];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4*NP-1:0] expected_scores();
    logic [4*NP-1:0] v;
    v = '0;
    for (int i = 0; i < NP; i++) v[4*i +: 4] = 4'(model_score[i]);
    return v;
  endfunction

  function automatic int lowest_set(input logic [NP-1:0] pat);
    for (int i = 0; i < NP; i++) if (pat[i]) return i;
    return 0;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_phase"},    bus.phase,    0);
    check({tag, "_answered"}, bus.answered, 0);
    check({tag, "_correct"},  bus.correct,  0);
    check({tag, "_winner"},   bus.winnerId, 0);
    check({tag, "_timeleft"}, bus.timeLeft, 0);
    check({tag, "_scores"},   bus.scores,   0);
  endtask

  task automatic wait_phase(input logic [1:0] p, input int budget, input string tag, output int n);
    n = budget;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (bus.phase === p) begin
        n = i + 1;
        break;
      end
    end
    check(tag, bus.phase, p);
  endtask

  task automatic pulse_start(input logic [1:0] key);
    @(posedge clock); #1;
    bus.start = 1'b1;
    bus.answerKey = key;
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.answerKey = 2'($urandom);
  endtask

  // One full question: start, buzz pattern, optional answer, then the RESULT hold and return to IDLE.
  task automatic do_round(input logic [NP-1:0] pat, input logic [1:0] key, input bit answer,
                          input logic [1:0] sel, input bit disturb);
    int  n, hold, exp_w;
    bit  ok, corr_stable;
    pulse_start(key);
    bus.buzz = pat;
    exp_w = lowest_set(pat);
    for (int k = 0; k <= 3; k++) begin
      @(negedge clock);
      if (k == 2) check("buzz_not_yet", bus.phase, 1);
      if (k == 3) check("buzz_edge3_answer", bus.phase, 2);
    end
    check("winner", bus.winnerId, exp_w);
    check("time_reload", bus.timeLeft, AT);
    if (disturb) begin
      bus.buzz = pat | NP'(1);
      @(posedge clock); #1;
      bus.start = 1'b1;
      bus.answerKey = ~key;
      @(posedge clock); #1;
      bus.start = 1'b0;
      repeat (3) @(negedge clock);
      check("late_buzz_winner", bus.winnerId, exp_w);
      check("start_ignored", bus.phase, 2);
    end
    if (answer) begin
      @(posedge clock); #1;
      bus.answerValid = 1'b1;
      bus.answerSel = sel;
      @(posedge clock); #1;
      bus.answerValid = 1'b0;
      bus.answerSel = 2'($urandom);
      wait_phase(2'd3, 5, "reach_result", n);
    end else begin
      wait_phase(2'd3, 40, "reach_result", n);
      check("answer_timeout_cycles", n, AT * CF);
    end
    ok = answer && (sel == key);
    if (ok) begin
      if (model_score[exp_w] < 15) model_score[exp_w]++;
    end else begin
`ifdef SCORE_PENALTY_EN
      if (model_score[exp_w] > 0) model_score[exp_w]--;
`endif
    end
    check("verdict", bus.correct, ok);
    check("scores", bus.scores, expected_scores());
    hold = 1;
    corr_stable = 1'b1;
    while (bus.answered === 1'b1 && hold < 20) begin
      @(negedge clock);
      if (bus.answered === 1'b1) begin
        hold++;
        if (bus.correct !== ok) corr_stable = 1'b0;
      end
    end
    check("answered_hold", hold, HOLD);
    check("correct_stable", corr_stable, 1);
    check("back_idle", bus.phase, 0);
    check("idle_correct", bus.correct, 0);
    bus.buzz = '0;
    repeat (4) @(negedge clock);
  endtask

  initial begin
    int  n;
    bit  saw_answered;
    logic [NP-1:0] pat;
    logic [1:0] key, sel;
    bit answer;

    bus.start = 1'b0;
    bus.answerKey = '0;
    bus.buzz = '0;
    bus.answerSel = '0;
    bus.answerValid = 1'b0;
    for (int i = 0; i < NP; i++) model_score[i] = 0;

    #2;
    check_all_zero("reset");
    #10;
    globalReset = 1'b0;

    // Correct answer by player 1.
    do_round(4'b0010, 2'd2, 1'b1, 2'd2, 1'b0);
    check("p1_score", bus.scores[7:4], 1);

    // Simultaneous buzz, late buzz[0] and start ignored in ANSWER, wrong answer.
    do_round(4'b1010, 2'd0, 1'b1, 2'd3, 1'b1);

    // OPEN timeout with nobody buzzing.
    pulse_start(2'd1);
    saw_answered = 1'b0;
    for (int k = 0; k <= AT * CF; k++) begin
      @(negedge clock);
      if (bus.answered === 1'b1) saw_answered = 1'b1;
      if (k < AT * CF) begin
        if (k % CF == CF - 1 || k % CF == 0) check("open_timeleft", bus.timeLeft, AT - k / CF);
        if (k == AT * CF - 1) check("open_still", bus.phase, 1);
      end else begin
        check("open_timeout_idle", bus.phase, 0);
      end
    end
    check("open_no_answered", saw_answered, 0);
    check("open_scores", bus.scores, expected_scores());

    // ANSWER timeout by player 3.
    do_round(4'b1000, 2'd1, 1'b0, 2'd0, 1'b0);
    check("p3_score", bus.scores[15:12], 0);

    // Player 0 saturation; first round also exercises start-in-ANSWER.
    for (int r = 0; r < 16; r++) begin
      key = 2'($urandom);
      do_round(4'b0001, key, 1'b1, key, r == 0);
    end
    check("p0_saturated", bus.scores[3:0], 15);

    // Randomized rounds.
    for (int r = 0; r < 10; r++) begin
      pat    = NP'($urandom_range(1, (1 << NP) - 1));
      key    = 2'($urandom);
      answer = ($urandom_range(0, 3) != 0);
      sel    = ($urandom_range(0, 1) != 0) ? key : 2'($urandom);
      do_round(pat, key, answer, sel, 1'b0);
    end

    // Asynchronous reset in the middle of RESULT.
    pulse_start(2'd1);
    bus.buzz = 4'b0100;
    wait_phase(2'd2, 10, "rst_reach_answer", n);
    @(posedge clock); #1;
    bus.answerValid = 1'b1;
    bus.answerSel = 2'd1;
    @(posedge clock); #1;
    bus.answerValid = 1'b0;
    wait_phase(2'd3, 5, "rst_reach_result", n);
    #2;
    globalReset = 1'b1;
    #1;
    check_all_zero("midreset");
    for (int i = 0; i < NP; i++) model_score[i] = 0;
    bus.buzz = '0;
    @(negedge clock);
    globalReset = 1'b0;
    repeat (2) @(negedge clock);
    do_round(4'b0100, 2'd3, 1'b1, 2'd3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/quiz_answer_judge.md
Name: quiz_answer_judge

Overview:
Upstream judge for the quiz-game LT24 result screen. It arbitrates contestant buzzers, runs the per-question countdown, and checks the winner's choice against the latched answer key. It drives the screen's answer-submitted level (answered) and correct flag (correct). It also keeps per-player saturating scores for the host.

Parameters:
NUM_PLAYERS, 4, number of buzzer inputs (2..8)
CLOCK_FREQ, 50000000, clock cycles per one-second tick
ANSWER_TIME_S, 10, countdown length in seconds for both OPEN and ANSWER phases (1..255)
RESULT_HOLD_CYCLES, 100000000, cycles the answered level is held in RESULT (>=1)

Ports:
clock  in  1  system clock
globalReset  in  1  asynchronous, active-high reset
start  in  1  one-cycle host pulse that opens a question
answerKey  in  2  correct option; latched on accepted start
buzz  in  NUM_PLAYERS  asynchronous contestant buttons, active-high
answerSel  in  2  option chosen by the current winner
answerValid  in  1  one-cycle strobe; answerSel is valid on this cycle
answered  out  1  high throughout RESULT (screen input x)
correct  out  1  verdict; valid only while answered=1, else 0 (screen input w)
winnerId  out  3  index of the last buzz winner
timeLeft  out  8  seconds remaining in the current phase
phase  out  2  0=IDLE, 1=OPEN, 2=ANSWER, 3=RESULT
scores  out  4*NUM_PLAYERS  packed 4-bit score per player; player i occupies bits [4i+3:4i]

Behaviour:
- Reset (asynchronous, immediate, including mid-question):
  - phase=IDLE; answered=0; correct=0; winnerId=0; timeLeft=0; scores=0.
  - Synchronizers, prescaler and latched key are cleared.
- Buzz input path:
  - Each buzz bit passes a 2-flop synchronizer, then a previous-value flop.
  - Rising edge = sync2 & ~prev.
  - A buzz that rises before clock edge 1 is acted on at edge 3.
- Tick prescaler:
  - Counts 0..CLOCK_FREQ-1 and restarts at 0 on every phase entry.
  - tick=1 when count==CLOCK_FREQ-1.
  - Each tick decrements timeLeft; timeout = tick while timeLeft==1.
- IDLE:
  - start -> OPEN; latch answerKey; timeLeft=ANSWER_TIME_S.
  - buzz and answerValid are ignored.
- OPEN:
  - Any buzz edge -> ANSWER. winnerId = lowest-indexed edge (simultaneous edges: lowest index wins). timeLeft reloads to ANSWER_TIME_S.
  - Timeout with no buzz -> IDLE; answered stays 0; scores unchanged.
  - Buzz edge and timeout on the same cycle: the buzz wins.
- ANSWER:
  - answerValid -> RESULT; correct=(answerSel==latched key).
  - If correct, score[winnerId] increments, saturating at 15.
  - Timeout -> RESULT with correct=0.
  - answerValid and timeout on the same cycle: answerValid wins.
  - Further buzz edges are ignored.
- RESULT:
  - answered=1 for exactly RESULT_HOLD_CYCLES cycles, then IDLE with answered=0 and correct=0.
  - timeLeft holds its value.
- Other rules:
  - start outside IDLE is ignored.
  - Scores change only on the RESULT entry cycle.
  - winnerId holds until the next buzz win.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
SCORE_PENALTY_EN
- Defined: entering RESULT with correct=0 after a winner (answerValid mismatch or ANSWER timeout) decrements score[winnerId], saturating at 0.
- Undefined: wrong answers and timeouts leave scores unchanged.

Test Plan:
All scenarios use CLOCK_FREQ=10, ANSWER_TIME_S=3, RESULT_HOLD_CYCLES=5.
- Correct answer: reset, start with answerKey=2, buzz[1] high -> phase=ANSWER at edge 3 with winnerId=1; answerValid with answerSel=2 -> answered=1 and correct=1 for exactly 5 cycles, scores[7:4]=1, then phase=IDLE.
- Simultaneous buzz: buzz=4'b1010 on the same cycle in OPEN -> winnerId=1. Later buzz[0] edges in ANSWER leave winnerId=1.
- OPEN timeout: start, no buzz -> timeLeft goes 3,2,1 at ticks every 10 cycles, then phase=IDLE after 30 cycles; answered never asserts.
- ANSWER timeout: winner 3, no answerValid for 30 cycles -> RESULT with correct=0. scores[15:12] stays 0 without the macro, and stays 0 (saturated) with SCORE_PENALTY_EN.
- Saturation and ignored start: 16 correct rounds for player 0 -> scores[3:0]=15. A start pulse in ANSWER has no effect.
- Mid-operation reset: globalReset during RESULT -> all outputs 0 and phase=IDLE with no clock edge needed.
